// File: rtl/reg_file_mp.sv
// Multi-read-port register file with post-reset clear sweep and busy flag.
// Optional write-first read bypass: define REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [WIDTH-1:0]          wd,
  input  logic [NUM_READ*AW-1:0]    ra,
  output logic [NUM_READ*WIDTH-1:0] rd,
  output logic                      busy
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [AW-1:0]        clr_idx;
  logic [AW-1:0]        clr_d;
  logic                 mem_we;
  logic [AW-1:0]        mem_wa;
  logic [WIDTH-1:0]     mem_wd;
  logic                 wr_zero;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [NUM_READ*WIDTH-1:0] rd_q;

  assign wr_zero = (ZERO_REG != 0) && (wa == '0);
  assign busy    = (state_q == CLEAR);
  assign rd      = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      clr_idx <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_idx;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_idx;
        mem_wd = '0;
        clr_d  = clr_idx + AW'(1);
        if (clr_idx == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        mem_we = we && !wr_zero;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Reads sample the array before this edge's write (read-first)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_READ; i++) begin
      if (rst || state_q == CLEAR) begin
        rd_q[i*WIDTH +: WIDTH] <= '0;
      end else if ((ZERO_REG != 0) && (ra[i*AW +: AW] == '0)) begin
        rd_q[i*WIDTH +: WIDTH] <= '0;
`ifdef REG_FILE_BYPASS_EN
      end else if (we && !wr_zero && (ra[i*AW +: AW] == wa)) begin
        rd_q[i*WIDTH +: WIDTH] <= wd;
`endif
      end else begin
        rd_q[i*WIDTH +: WIDTH] <= mem[ra[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default, ZERO_REG=0 and 64x8x3 instances.
module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra0;
  logic [4:0]  ra1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [63:0] rd_z;
  logic        busy;
  logic        busy_z;

  logic         wwe;
  logic [2:0]   wwa;
  logic [63:0]  wwd;
  logic [2:0]   wra0;
  logic [2:0]   wra1;
  logic [2:0]   wra2;
  logic [8:0]   wra;
  logic [191:0] wrd;
  logic         wbusy;

  int nvec;
  int nerr;

  assign ra  = {ra1, ra0};
  assign wra = {wra2, wra1, wra0};

  reg_file_mp u_dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .busy(busy)
  );

  reg_file_mp #(.ZERO_REG(0)) u_z0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_z), .busy(busy_z)
  );

  reg_file_mp #(.WIDTH(64), .DEPTH(8), .NUM_READ(3)) u_wide (
    .clk(clk), .rst(rst), .we(wwe), .wa(wwa), .wd(wwd),
    .ra(wra), .rd(wrd), .busy(wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name, input int exp_n,
                       input bit chk_wide);
    int n;
    int wn;
    n  = 0;
    wn = 0;
    do begin
      step();
      n++;
      if (!wbusy && wn == 0) wn = n;
    end while (busy && n < 100);
    chk(name, 64'(n), 64'(exp_n));
    if (chk_wide) chk({name, "_wide"}, 64'(wn), 64'd8);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd0,  5'd0,
                 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
                 32'h12345678, 32'h12345678};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd7,
                 32'h12345678, 32'h12345678};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,
                 32'h0, 32'h12345678};
    vecs[4]  = '{1'b1, 5'd3,  32'hA,        5'd3,  5'd0,
                 BYP ? 32'hA : 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd3,  32'hB,        5'd3,  5'd3,
                 BYP ? 32'hB : 32'hA, BYP ? 32'hB : 32'hA};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd7,
                 32'hB, 32'h12345678};
    vecs[7]  = '{1'b1, 5'd9,  32'h55,       5'd9,  5'd3,
                 BYP ? 32'h55 : 32'h0, 32'hB};
    vecs[8]  = '{1'b1, 5'd0,  32'h77,       5'd0,  5'd0,
                 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,
                 32'h55, 32'h0};
    vecs[10] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30,
                 BYP ? 32'h80000001 : 32'h0, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,
                 32'h80000001, 32'h0};

    rst = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hDEAD;
    ra0 = 5'd0; ra1 = 5'd0;
    wwe = 1'b0; wwa = '0; wwd = '0;
    wra0 = '0; wra1 = '0; wra2 = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_rd", rd, 64'h0);
    end
    rst = 1'b0;
    sweep("sweep_len", 32, 1'b1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_rd", rd, 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep("resweep_len", 32, 1'b0);
    we = 1'b0;

    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      step();
      chk($sformatf("clr_%0d", a), rd, 64'h0);
    end

    for (int i = 0; i < 12; i++) begin
      we  = vecs[i].we;
      wa  = vecs[i].wa;
      wd  = vecs[i].wd;
      ra0 = vecs[i].a0;
      ra1 = vecs[i].a1;
      step();
      chk($sformatf("vec%0d", i), rd, {vecs[i].e1, vecs[i].e0});
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    we = 1'b0; ra0 = 5'd0; ra1 = 5'd3;
    step();
    chk("zr_main", rd, {32'hB, 32'h0});
    chk("zr_z0", rd_z, {32'hB, 32'h77});
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    step();
    we = 1'b0;
    step();
    chk("zr_main_ff", rd[31:0], 64'h0);
    chk("zr_z0_ff", rd_z[31:0], 64'hFFFFFFFF);

    wwe = 1'b1; wwa = 3'd6; wwd = 64'hCAFEF00DCAFEF00D;
    step();
    wwe = 1'b0;
    wra0 = 3'd6; wra1 = 3'd6; wra2 = 3'd6;
    step();
    chk("wide_p0", wrd[63:0], 64'hCAFEF00DCAFEF00D);
    chk("wide_p1", wrd[127:64], 64'hCAFEF00DCAFEF00D);
    chk("wide_p2", wrd[191:128], 64'hCAFEF00DCAFEF00D);
    wra1 = 3'd0; wra2 = 3'd5;
    step();
    chk("wide_mix", wrd, {64'h0, 64'h0, 64'hCAFEF00DCAFEF00D});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
